reg_dump_streamer: RTL and testbench
====================================

Name: reg_dump_streamer

Overview:
Debug read-out engine for the Mips core's register read-out port (reg_out_id / reg_out_data). On a start pulse it walks a range of register IDs, samples each value and streams it out as (id, data) beats over a valid/ready handshake. It replaces bench-side polling of the register read-out port. It feeds result checkers and the UART/trace path.

Parameters:
NUM_REGS, 32, number of architectural registers; IDs wrap modulo NUM_REGS.
ID_WIDTH, 5, width of register IDs, equal to log2(NUM_REGS).
DATA_WIDTH, 32, register data width.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous reset, active-high.
start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
first_id  input  ID_WIDTH  first register of the range; sampled on an accepted start.
last_id  input  ID_WIDTH  last register of the range, inclusive; sampled on an accepted start.
busy  output  1  high from an accepted start until the final beat is popped.
done  output  1  one-cycle pulse in the cycle after the final beat handshakes.
reg_out_id  output  ID_WIDTH  register select driven to the Mips read-out port (registered).
reg_out_data  input  DATA_WIDTH  combinational read-out data for reg_out_id.
out_valid  output  1  output beat available.
out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
out_id  output  ID_WIDTH  register ID of the current beat.
out_data  output  DATA_WIDTH  register value of the current beat.
out_last  output  1  high on the final beat of a dump.
out_sum  output  1  high on a checksum beat; tied 0 unless REG_DUMP_CHECKSUM_EN is defined.

Behaviour:
- Reset (asynchronous, any cycle, including mid-dump):
  - FSM returns to IDLE and the buffer is emptied.
  - busy, done, out_valid, out_last and out_sum go to 0.
  - reg_out_id, out_id and out_data go to 0.
  - Any in-progress dump is discarded; no partial beats appear after reset.
- FSM states:
  - IDLE: waits for start.
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for the buffer to empty.
  - Completion: done pulses and the FSM returns to IDLE in the same transition.
- start accepted (IDLE):
  - Latch first_id/last_id.
  - count = ((last_id - first_id) mod NUM_REGS) + 1, so first_id == last_id gives 1 word, and first_id > last_id wraps through NUM_REGS-1 to 0.
  - reg_out_id <= first_id; enter RUN; busy = 1 the next cycle.
- start while busy: ignored, with no effect on the current dump.
- RUN, per cycle:
  - If the 2-entry output buffer has a free slot (counting a pop in the same cycle), push {reg_out_id, reg_out_data}.
  - Then advance reg_out_id by 1, wrapping modulo NUM_REGS, and decrement the remaining count.
  - With out_ready held high, throughput is 1 beat per cycle.
  - With out_ready held low, at most 2 beats are buffered; no read is issued, and reg_out_id holds its value while full.
- Latency: first out_valid appears 2 cycles after the cycle in which start is accepted.
- Ordering: beats are emitted strictly in ID order with no drops or duplicates.
- Output stability: out_id, out_data and out_last are stable while out_valid && !out_ready.
- out_last is set on the beat carrying the final ID (or the checksum beat when that feature is enabled).
- Remaining count reaching 0 moves the FSM RUN -> DRAIN.
- DRAIN -> IDLE occurs on the handshake of the out_last beat; done = 1 for exactly the following cycle; busy drops in that same cycle.
- Simultaneous push and pop with a full buffer is legal; occupancy stays at 2.
- A new start is accepted in the cycle done is high, since the FSM is already in IDLE.

Optional Feature:
REG_DUMP_CHECKSUM_EN:
- Defined:
  - A running XOR of every emitted out_data is kept, cleared on an accepted start.
  - After the last register beat, one extra beat is emitted: out_data = XOR value, out_id = latched last_id, out_sum = 1, out_last = 1.
  - The register beat before it has out_last = 0.
- Undefined:
  - No accumulator and no extra beat; out_sum is constant 0.

Test Plan:
1. first_id=0, last_id=3, regs = 0,5,10,15, out_ready=1 -> 4 consecutive beats (0,0),(1,5),(2,10),(3,15); out_last only on id 3; done pulses 1 cycle after; busy low afterwards.
2. first_id=30, last_id=1 -> ids 30,31,0,1 in order (wrap); first_id=last_id=7 -> exactly one beat, with out_last=1.
3. Dump ids 0..7 with out_ready toggled 1,0,0,1 repeating -> all 8 beats delivered in order; data stable while stalled; reg_out_id frozen while the buffer is full.
4. Assert reset mid-dump after 3 beats -> outputs 0 immediately; no further beats; a new start 0..1 completes normally with 2 beats.
5. start pulsed again during a busy dump -> ignored; beat count unchanged.
6. REG_DUMP_CHECKSUM_EN, regs 1..3 = 0x1,0x2,0x4 -> 4th beat out_data=0x7, out_sum=1, out_last=1, out_id=3.

Source files
------------

// File: rtl/reg_dump_streamer.sv
// Debug read-out engine: walks a register ID range on the Mips read-out port and streams (id, data) beats.
// Optional feature macro REG_DUMP_CHECKSUM_EN appends an XOR checksum beat after the final register.
module reg_dump_streamer #(
    parameter int NUM_REGS   = 32,
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ID_WIDTH-1:0]   first_id,
    input  logic [ID_WIDTH-1:0]   last_id,
    output logic                  busy,
    output logic                  done,
    output logic [ID_WIDTH-1:0]   reg_out_id,
    input  logic [DATA_WIDTH-1:0] reg_out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_sum
);
    localparam int CNT_W = $clog2(NUM_REGS + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
`ifdef REG_DUMP_CHECKSUM_EN
        logic                  sum;
`endif
    } beat_t;

    state_t           state_q, state_d;
    beat_t            buf_q [2];
    beat_t            push_beat, head;
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       occ_q;
    logic [CNT_W-1:0] remaining_q, span;
    logic             done_q;
    logic             start_acc, push, pop, finish, can_push;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [ID_WIDTH-1:0]   last_id_q;
    logic [DATA_WIDTH-1:0] sum_q;
`endif

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (int'(id) == NUM_REGS - 1) ? '0 : id + 1'b1;
    endfunction

    assign head      = buf_q[rd_ptr_q];
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still take a push.
    assign can_push  = (occ_q != 2'd2) || pop;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign out_id   = head.id;
    assign out_data = head.data;
    assign out_last = head.last;
`ifdef REG_DUMP_CHECKSUM_EN
    assign out_sum  = head.sum;
`else
    assign out_sum  = 1'b0;
`endif

    // Words in the range, wrapping through NUM_REGS-1 to 0 when first_id > last_id.
    always_comb begin
        if (last_id >= first_id)
            span = CNT_W'(last_id) - CNT_W'(first_id) + CNT_W'(1);
        else
            span = CNT_W'(NUM_REGS) - CNT_W'(first_id) + CNT_W'(last_id) + CNT_W'(1);
`ifdef REG_DUMP_CHECKSUM_EN
        span = span + CNT_W'(1);
`endif
    end

    always_comb begin
        push_beat.id   = reg_out_id;
        push_beat.data = reg_out_data;
        push_beat.last = (remaining_q == CNT_W'(1));
`ifdef REG_DUMP_CHECKSUM_EN
        push_beat.sum  = 1'b0;
        if (remaining_q == CNT_W'(1)) begin
            push_beat.id   = last_id_q;
            push_beat.data = sum_q;
            push_beat.sum  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        push      = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                start_acc = 1'b1;
                state_d   = RUN;
            end
            RUN: if (can_push) begin
                push = 1'b1;
                if (remaining_q == CNT_W'(1)) state_d = DRAIN;
            end
            DRAIN: if (pop && head.last) begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            remaining_q <= '0;
            reg_out_id  <= '0;
            done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            last_id_q   <= '0;
            sum_q       <= '0;
`endif
        end else begin
            done_q <= finish;
            if (start_acc) begin
                reg_out_id  <= first_id;
                remaining_q <= span;
`ifdef REG_DUMP_CHECKSUM_EN
                last_id_q   <= last_id;
                sum_q       <= '0;
`endif
            end
            if (push) begin
                buf_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= ~wr_ptr_q;
                remaining_q     <= remaining_q - CNT_W'(1);
                reg_out_id      <= next_id(reg_out_id);
`ifdef REG_DUMP_CHECKSUM_EN
                if (!push_beat.sum) sum_q <= sum_q ^ push_beat.data;
`endif
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer; REG_DUMP_CHECKSUM_EN adds the checksum scenario and extra beat.
module tb_reg_dump_streamer;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [4:0]  first_id = '0, last_id = '0;
    logic        busy, done, out_valid, out_last, out_sum;
    logic [4:0]  reg_out_id, out_id;
    logic [31:0] reg_out_data, out_data;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic [31:0] regs [32];
    assign reg_out_data = regs[reg_out_id];

    reg_dump_streamer #(.NUM_REGS(32), .ID_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .first_id(first_id), .last_id(last_id),
        .busy(busy), .done(done), .reg_out_id(reg_out_id), .reg_out_data(reg_out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
        .out_last(out_last), .out_sum(out_sum)
    );

    always #5 clock = ~clock;

    int          passed = 0, total = 0;
    logic [4:0]  q_id [$];
    logic [31:0] q_data [$];
    logic        q_last [$], q_sum [$];
    int          first_c, done_c, stall_viol;
    logic        busy_at_done;

    task automatic kick(input logic [4:0] f, input logic [4:0] l);
        @(negedge clock); first_id = f; last_id = l; start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    // Records handshaken beats until done, max_beats or max_cyc; pat 1 toggles ready 1,0,0,1.
    task automatic collect(input int pat, input int max_beats, input int max_cyc);
        logic [4:0] pid; logic [31:0] pdata; logic plast; logic stalled;
        stalled = 1'b0; pid = '0; pdata = '0; plast = 1'b0;
        q_id.delete(); q_data.delete(); q_last.delete(); q_sum.delete();
        first_c = -1; done_c = -1; stall_viol = 0; busy_at_done = 1'bx;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) @(negedge clock);
            out_ready = (pat == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            #1;
            if (stalled && (out_id !== pid || out_data !== pdata || out_last !== plast)) stall_viol++;
            stalled = out_valid && !out_ready; pid = out_id; pdata = out_data; plast = out_last;
            if (out_valid && first_c < 0) first_c = c;
            if (done) begin done_c = c; busy_at_done = busy; break; end
            if (out_valid && out_ready) begin
                q_id.push_back(out_id); q_data.push_back(out_data);
                q_last.push_back(out_last); q_sum.push_back(out_sum);
                if (q_id.size() == max_beats) break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        #1;
        total++; if ({busy, done, out_valid, out_last, out_sum} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, done, out_valid, out_last, out_sum}); else passed++;
        total++; if (reg_out_id !== 5'd0) $display("FAIL reset_reg_out_id: got %0d want 0", reg_out_id); else passed++;
        total++; if ({out_id, out_data} !== 37'd0) $display("FAIL reset_out: got id=%0d data=%0h want 0/0", out_id, out_data); else passed++;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 32; i++) regs[i] = 32'(5 * i);
        kick(5'd0, 5'd3);
        collect(0, 99, 50);
        total++; if (first_c !== 1) $display("FAIL basic_latency: got first valid cycle %0d want 1", first_c); else passed++;
        total++; if (q_id.size() !== 4 + EXTRA) $display("FAIL basic_count: got %0d want %0d", q_id.size(), 4 + EXTRA); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_id[i] !== 5'(i) || q_data[i] !== 32'(5 * i) || q_last[i] !== 1'(i == 3 && EXTRA == 0) || q_sum[i] !== 1'b0)
                $display("FAIL basic_beat%0d: got id=%0d data=%0d last=%b sum=%b want id=%0d data=%0d last=%b sum=0",
                         i, q_id[i], q_data[i], q_last[i], q_sum[i], i, 5 * i, (i == 3 && EXTRA == 0));
            else passed++;
        end
        total++; if (done_c !== 5 + EXTRA) $display("FAIL basic_done_cycle: got %0d want %0d", done_c, 5 + EXTRA); else passed++;
        total++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); else passed++;
        @(negedge clock); #1;
        total++; if ({done, busy} !== 2'b00) $display("FAIL basic_done_pulse: got done=%b busy=%b want 0/0", done, busy); else passed++;
    endtask

    task automatic test_wrap;
        logic [4:0] exp_ids [4];
        exp_ids = '{5'd30, 5'd31, 5'd0, 5'd1};
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000 + 32'(i);
        kick(5'd30, 5'd1);
        collect(0, 99, 50);
        total++; if (q_id.size() !== 4 + EXTRA) $display("FAIL wrap_count: got %0d want %0d", q_id.size(), 4 + EXTRA); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_id[i] !== exp_ids[i] || q_data[i] !== 32'hA000 + 32'(exp_ids[i]))
                $display("FAIL wrap_beat%0d: got id=%0d data=%0h want id=%0d data=%0h", i, q_id[i], q_data[i], exp_ids[i], 32'hA000 + 32'(exp_ids[i]));
            else passed++;
        end
        total++; if (done_c < 0) $display("FAIL wrap_done: got no done want done"); else passed++;
        kick(5'd7, 5'd7);
        collect(0, 99, 50);
        total++; if (q_id.size() !== 1 + EXTRA) $display("FAIL single_count: got %0d want %0d", q_id.size(), 1 + EXTRA); else passed++;
        total++;
        if (q_id[0] !== 5'd7 || q_data[0] !== 32'hA007 || q_last[0] !== 1'(EXTRA == 0))
            $display("FAIL single_beat: got id=%0d data=%0h last=%b want id=7 data=a007 last=%b", q_id[0], q_data[0], q_last[0], (EXTRA == 0));
        else passed++;
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 32; i++) regs[i] = 32'(3 * i + 7);
        out_ready = 1'b0;
        kick(5'd0, 5'd7);
        repeat (4) @(negedge clock);
        #1;
        total++; if ({out_valid, out_id, out_data} !== {1'b1, 5'd0, 32'd7}) $display("FAIL stall_head: got v=%b id=%0d data=%0d want v=1 id=0 data=7", out_valid, out_id, out_data); else passed++;
        total++; if (reg_out_id !== 5'd2) $display("FAIL stall_reg_out_id: got %0d want 2", reg_out_id); else passed++;
        repeat (2) @(negedge clock);
        #1;
        total++; if (reg_out_id !== 5'd2) $display("FAIL stall_frozen: got %0d want 2", reg_out_id); else passed++;
        collect(1, 99, 200);
        total++; if (q_id.size() !== 8 + EXTRA) $display("FAIL bp_count: got %0d want %0d", q_id.size(), 8 + EXTRA); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (q_id[i] !== 5'(i) || q_data[i] !== 32'(3 * i + 7))
                $display("FAIL bp_beat%0d: got id=%0d data=%0d want id=%0d data=%0d", i, q_id[i], q_data[i], i, 3 * i + 7);
            else passed++;
        end
        total++; if (stall_viol !== 0) $display("FAIL bp_stability: got %0d changes while stalled want 0", stall_viol); else passed++;
        total++; if (done_c < 0) $display("FAIL bp_done: got no done want done"); else passed++;
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
        out_ready = 1'b1;
        kick(5'd0, 5'd7);
        collect(0, 3, 50);
        total++; if (q_id.size() !== 3) $display("FAIL midrst_pre_count: got %0d want 3", q_id.size()); else passed++;
        @(posedge clock); #2; reset = 1'b1; #1;
        total++; if ({busy, out_valid, out_last} !== 3'b0) $display("FAIL midrst_flags: got busy=%b valid=%b last=%b want 0", busy, out_valid, out_last); else passed++;
        total++; if ({reg_out_id, out_id, out_data} !== 42'd0) $display("FAIL midrst_outputs: got rid=%0d id=%0d data=%0h want 0", reg_out_id, out_id, out_data); else passed++;
        repeat (3) @(negedge clock);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_hold: got valid=%b want 0", out_valid); else passed++;
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        total++; if ({busy, out_valid} !== 2'b00) $display("FAIL midrst_no_beats: got busy=%b valid=%b want 0/0", busy, out_valid); else passed++;
        kick(5'd0, 5'd1);
        collect(0, 99, 50);
        total++; if (q_id.size() !== 2 + EXTRA) $display("FAIL midrst_count: got %0d want %0d", q_id.size(), 2 + EXTRA); else passed++;
        total++;
        if (q_id[0] !== 5'd0 || q_data[0] !== 32'h100 || q_id[1] !== 5'd1 || q_data[1] !== 32'h101)
            $display("FAIL midrst_beats: got %0d/%0h %0d/%0h want 0/100 1/101", q_id[0], q_data[0], q_id[1], q_data[1]);
        else passed++;
        total++; if (done_c < 0) $display("FAIL midrst_done: got no done want done"); else passed++;
    endtask

    task automatic test_restart_ignored;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * i);
        out_ready = 1'b0;
        kick(5'd0, 5'd5);
        @(negedge clock); first_id = 5'd20; last_id = 5'd25; start = 1'b1;
        @(negedge clock); start = 1'b0;
        collect(0, 99, 100);
        total++; if (q_id.size() !== 6 + EXTRA) $display("FAIL restart_count: got %0d want %0d", q_id.size(), 6 + EXTRA); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (q_id[i] !== 5'(i) || q_data[i] !== 32'(i * i))
                $display("FAIL restart_beat%0d: got id=%0d data=%0d want id=%0d data=%0d", i, q_id[i], q_data[i], i, i * i);
            else passed++;
        end
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum;
        regs[1] = 32'h1; regs[2] = 32'h2; regs[3] = 32'h4;
        kick(5'd1, 5'd3);
        collect(0, 99, 50);
        total++; if (q_id.size() !== 4) $display("FAIL sum_count: got %0d want 4", q_id.size()); else passed++;
        total++; if ({q_last[2], q_sum[2]} !== 2'b00) $display("FAIL sum_prev_last: got last=%b sum=%b want 0/0", q_last[2], q_sum[2]); else passed++;
        total++;
        if (q_id[3] !== 5'd3 || q_data[3] !== 32'h7 || q_last[3] !== 1'b1 || q_sum[3] !== 1'b1)
            $display("FAIL sum_beat: got id=%0d data=%0h last=%b sum=%b want 3/7/1/1", q_id[3], q_data[3], q_last[3], q_sum[3]);
        else passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_mid_reset();
        test_restart_ignored();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
